// File: rtl/screen_memarb_pkg.sv
// Shared types for the screen/CPU external-memory arbiter.
package screen_memarb_pkg;

    localparam int ID_W = 1;

    typedef enum logic [ID_W-1:0] {
        ID_SCR = 1'b0,
        ID_CPU = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        LK_IDLE = 2'd0,
        LK_SCR  = 2'd1,
        LK_CPU  = 2'd2
    } lock_state_t;

endpackage

// File: rtl/screen_memarb_idq.sv
// In-order queue of requester IDs for addresses accepted by memory but still awaiting data.
module screen_memarb_idq
    import screen_memarb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  req_id_t       i_push_id,
    input  logic          i_pop,
    output logic          o_empty,
    output req_id_t       o_head,
    output logic [PW:0]   o_count
);

    req_id_t       r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    assign w_push = i_push && !w_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_id;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/screen_mem_arbiter.sv
// Shares one external-memory port between the screen fetcher (high priority) and the CPU.
// Define SCREEN_MEMARB_STARVE_GUARD_EN to force a CPU grant after STARVE_LIM back-to-back screen grants.
module screen_mem_arbiter
    import screen_memarb_pkg::*;
#(
    parameter int AW         = 20,
    parameter int DW         = 16,
    parameter int OUTST      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_scr_addr_vld,
    output logic          o_scr_addr_gnt,
    input  logic [AW-1:0] i_scr_addr,
    output logic          o_scr_dat_vld,
    input  logic          i_scr_dat_gnt,
    output logic [DW-1:0] o_scr_dat,
    input  logic          i_cpu_addr_vld,
    output logic          o_cpu_addr_gnt,
    input  logic [AW-1:0] i_cpu_addr,
    output logic          o_cpu_dat_vld,
    input  logic          i_cpu_dat_gnt,
    output logic [DW-1:0] o_cpu_dat,
    output logic          o_mem_addr_vld,
    input  logic          i_mem_addr_gnt,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_dat_vld,
    output logic          o_mem_dat_gnt,
    input  logic [DW-1:0] i_mem_dat,
    output logic          o_err_unexp
);

    localparam int CW = $clog2(OUTST);

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    req_id_t     w_sel;
    req_id_t     w_head;
    logic        w_empty;
    logic [CW:0] w_count;
    logic        w_space;
    logic        w_addr_hs;
    logic        w_dat_hs;
    logic        w_force_cpu;
    logic        r_err;

`ifdef SCREEN_MEMARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIM + 1);
    logic [SW-1:0] r_starve;

    assign w_force_cpu = (r_starve == SW'(STARVE_LIM)) && i_cpu_addr_vld;

    // Counts screen grants taken while the CPU sits waiting; saturates at the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (!i_cpu_addr_vld || (w_addr_hs && w_sel == ID_CPU)) begin
            r_starve <= '0;
        end else if (w_addr_hs && w_sel == ID_SCR && r_starve != SW'(STARVE_LIM)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_force_cpu = 1'b0;
`endif

    // A stalled address keeps its owner selected so mem_addr cannot change under memory.
    always_comb begin
        w_sel = ID_SCR;
        case (r_state)
            LK_SCR:  w_sel = ID_SCR;
            LK_CPU:  w_sel = ID_CPU;
            default: if (w_force_cpu || !i_scr_addr_vld) w_sel = ID_CPU;
        endcase
    end

    assign w_space        = (w_count < (CW+1)'(OUTST));
    assign o_mem_addr_vld = w_space && ((w_sel == ID_SCR) ? i_scr_addr_vld : i_cpu_addr_vld);
    assign o_mem_addr     = (w_sel == ID_SCR) ? i_scr_addr : i_cpu_addr;
    assign w_addr_hs      = o_mem_addr_vld && i_mem_addr_gnt;
    assign o_scr_addr_gnt = w_addr_hs && (w_sel == ID_SCR);
    assign o_cpu_addr_gnt = w_addr_hs && (w_sel == ID_CPU);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LK_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LK_IDLE: begin
                if (o_mem_addr_vld && !i_mem_addr_gnt) begin
                    w_state_nxt = (w_sel == ID_SCR) ? LK_SCR : LK_CPU;
                end
            end
            LK_SCR, LK_CPU: begin
                if (w_addr_hs) w_state_nxt = LK_IDLE;
            end
            default: w_state_nxt = LK_IDLE;
        endcase
    end

    // Returned data is steered to whichever requester owns the oldest accepted address.
    always_comb begin
        o_scr_dat_vld = 1'b0;
        o_cpu_dat_vld = 1'b0;
        o_mem_dat_gnt = 1'b0;
        if (!w_empty) begin
            if (w_head == ID_SCR) begin
                o_scr_dat_vld = i_mem_dat_vld;
                o_mem_dat_gnt = i_scr_dat_gnt;
            end else begin
                o_cpu_dat_vld = i_mem_dat_vld;
                o_mem_dat_gnt = i_cpu_dat_gnt;
            end
        end
    end

    assign o_scr_dat = i_mem_dat;
    assign o_cpu_dat = i_mem_dat;
    assign w_dat_hs  = i_mem_dat_vld && o_mem_dat_gnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_mem_dat_vld && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign o_err_unexp = r_err;

    screen_memarb_idq #(
        .DEPTH (OUTST)
    ) u_idq (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (w_addr_hs),
        .i_push_id (w_sel),
        .i_pop     (w_dat_hs),
        .o_empty   (w_empty),
        .o_head    (w_head),
        .o_count   (w_count)
    );

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Self-checking bench for screen_mem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based behavioural model (honours SCREEN_MEMARB_STARVE_GUARD_EN).
module tb_screen_mem_arbiter;

    localparam int AW         = 20;
    localparam int DW         = 16;
    localparam int OUTST      = 4;
    localparam int STARVE_LIM = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scrAddrVld = 1'b0, cpuAddrVld = 1'b0, memAddrGnt = 1'b0, memDatVld = 1'b0;
    logic          scrDatGnt = 1'b0, cpuDatGnt = 1'b0;
    logic [AW-1:0] scrAddr = '0, cpuAddr = '0;
    logic [DW-1:0] memDat = '0;

    logic          scrAddrGnt, cpuAddrGnt, scrDatVld, cpuDatVld, memAddrVld, memDatGnt, errUnexp;
    logic [AW-1:0] memAddrO;
    logic [DW-1:0] scrDatO, cpuDatO;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    screen_mem_arbiter #(
        .AW(AW), .DW(DW), .OUTST(OUTST), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_scr_addr_vld(scrAddrVld), .o_scr_addr_gnt(scrAddrGnt), .i_scr_addr(scrAddr),
        .o_scr_dat_vld(scrDatVld), .i_scr_dat_gnt(scrDatGnt), .o_scr_dat(scrDatO),
        .i_cpu_addr_vld(cpuAddrVld), .o_cpu_addr_gnt(cpuAddrGnt), .i_cpu_addr(cpuAddr),
        .o_cpu_dat_vld(cpuDatVld), .i_cpu_dat_gnt(cpuDatGnt), .o_cpu_dat(cpuDatO),
        .o_mem_addr_vld(memAddrVld), .i_mem_addr_gnt(memAddrGnt), .o_mem_addr(memAddrO),
        .i_mem_dat_vld(memDatVld), .o_mem_dat_gnt(memDatGnt), .i_mem_dat(memDat),
        .o_err_unexp(errUnexp)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: owners of accepted-but-unanswered addresses (0=SCR, 1=CPU), the owner of an address
    // memory has seen but not yet taken, the sticky error and the run of screen grants the CPU waited through.
    int modelQ[$];
    int pendOwner = -1;
    bit errFlag = 1'b0;
    int starveCnt = 0;
    bit lastScrHs = 1'b0, lastCpuHs = 1'b0, lastMemDatHs = 1'b0;

    int            selM, headM;
    bit            starvedM, expMemVld, addrHsM, expScrDv, expCpuDv, expMemDatGnt;
    logic [AW-1:0] expAddr;

    always @(negedge clk) begin
        if (rst) begin
            modelQ.delete();
            pendOwner    = -1;
            errFlag      = 1'b0;
            starveCnt    = 0;
            lastScrHs    = 1'b0;
            lastCpuHs    = 1'b0;
            lastMemDatHs = 1'b0;
        end else begin
            starvedM = 1'b0;
`ifdef SCREEN_MEMARB_STARVE_GUARD_EN
            starvedM = (starveCnt >= STARVE_LIM) && cpuAddrVld;
`endif
            if (pendOwner >= 0)                 selM = pendOwner;
            else if (starvedM || !scrAddrVld)   selM = 1;
            else                                selM = 0;
            expMemVld = (modelQ.size() < OUTST) && ((selM == 0) ? scrAddrVld : cpuAddrVld);
            expAddr   = (selM == 0) ? scrAddr : cpuAddr;
            addrHsM   = expMemVld && memAddrGnt;
            expScrDv = 1'b0; expCpuDv = 1'b0; expMemDatGnt = 1'b0;
            if (modelQ.size() > 0) begin
                headM        = modelQ[0];
                expScrDv     = memDatVld && (headM == 0);
                expCpuDv     = memDatVld && (headM == 1);
                expMemDatGnt = (headM == 0) ? scrDatGnt : cpuDatGnt;
            end

            checkOutput("mem_addr_vld", memAddrVld, expMemVld);
            checkOutput("mem_addr", memAddrO, expAddr);
            checkOutput("scr_addr_gnt", scrAddrGnt, addrHsM && selM == 0);
            checkOutput("cpu_addr_gnt", cpuAddrGnt, addrHsM && selM == 1);
            checkOutput("scr_dat_vld", scrDatVld, expScrDv);
            checkOutput("cpu_dat_vld", cpuDatVld, expCpuDv);
            checkOutput("mem_dat_gnt", memDatGnt, expMemDatGnt);
            checkOutput("scr_dat", scrDatO, memDat);
            checkOutput("cpu_dat", cpuDatO, memDat);
            checkOutput("err_unexp", errUnexp, errFlag);

            if (memDatVld && modelQ.size() == 0) errFlag = 1'b1;
            lastMemDatHs = memDatVld && expMemDatGnt;
            if (lastMemDatHs) void'(modelQ.pop_front());
            if (addrHsM) modelQ.push_back(selM);
            pendOwner = addrHsM ? -1 : (expMemVld ? selM : pendOwner);
            if (!cpuAddrVld || (addrHsM && selM == 1)) starveCnt = 0;
            else if (addrHsM && selM == 0)             starveCnt++;
            lastScrHs = addrHsM && selM == 0;
            lastCpuHs = addrHsM && selM == 1;
        end
    end

    task automatic applyStimulus(input logic sv, input logic [AW-1:0] sa, input logic cv, input logic [AW-1:0] ca,
                                 input logic mag, input logic mdv, input logic [DW-1:0] md,
                                 input logic sdg, input logic cdg);
        @(posedge clk); #1;
        scrAddrVld = sv; scrAddr = sa; cpuAddrVld = cv; cpuAddr = ca;
        memAddrGnt = mag; memDatVld = mdv; memDat = md; scrDatGnt = sdg; cpuDatGnt = cdg;
    endtask

    task automatic sampleWindow();
        @(negedge clk); #1;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        scrAddrVld = 0; cpuAddrVld = 0; memAddrGnt = 0; memDatVld = 0; scrDatGnt = 0; cpuDatGnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int firstCpuGrant, grantNo, cpuGrants, scrIdx;
        bit scrTaken;

        $display("[TB] reset and both-request ordering");
        doReset();
        sampleWindow();
        checkOutput("rst_mem_addr_vld", memAddrVld, 0);
        checkOutput("rst_scr_addr_gnt", scrAddrGnt, 0);
        checkOutput("rst_cpu_addr_gnt", cpuAddrGnt, 0);
        checkOutput("rst_mem_dat_gnt", memDatGnt, 0);
        checkOutput("rst_err_unexp", errUnexp, 0);
        applyStimulus(1, 20'h00100, 1, 20'h80000, 1, 0, 0, 1, 1);
        sampleWindow();
        checkOutput("both_mem_addr", memAddrO, 20'h00100);
        checkOutput("both_scr_gnt", scrAddrGnt, 1);
        checkOutput("both_cpu_gnt", cpuAddrGnt, 0);
        applyStimulus(0, 0, 1, 20'h80000, 1, 0, 0, 1, 1);
        sampleWindow();
        checkOutput("second_mem_addr", memAddrO, 20'h80000);
        checkOutput("second_cpu_gnt", cpuAddrGnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 16'hD0D0, 1, 1);
        sampleWindow();
        checkOutput("d0_scr_vld", scrDatVld, 1);
        checkOutput("d0_scr_dat", scrDatO, 16'hD0D0);
        checkOutput("d0_cpu_vld", cpuDatVld, 0);
        checkOutput("d0_mem_dat_gnt", memDatGnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 16'hD1D1, 1, 1);
        sampleWindow();
        checkOutput("d1_cpu_vld", cpuDatVld, 1);
        checkOutput("d1_cpu_dat", cpuDatO, 16'hD1D1);
        checkOutput("d1_scr_vld", scrDatVld, 0);

        $display("[TB] stalled screen address holds lock");
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 20'h12345, 1, 20'h54321, 0, 0, 0, 0, 0);
            sampleWindow();
            checkOutput("stall_mem_addr", memAddrO, 20'h12345);
            checkOutput("stall_mem_addr_vld", memAddrVld, 1);
            checkOutput("stall_cpu_gnt", cpuAddrGnt, 0);
        end
        applyStimulus(1, 20'h12345, 1, 20'h54321, 1, 0, 0, 0, 0);
        sampleWindow();
        checkOutput("stall_release_scr_gnt", scrAddrGnt, 1);
        applyStimulus(0, 0, 1, 20'h54321, 1, 0, 0, 0, 0);
        sampleWindow();
        checkOutput("stall_after_cpu_gnt", cpuAddrGnt, 1);
        checkOutput("stall_after_mem_addr", memAddrO, 20'h54321);

        $display("[TB] outstanding limit");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 20'h00400 + 20'(i), 1, 0, 0, 0, 0);
            sampleWindow();
            checkOutput("fill_cpu_gnt", cpuAddrGnt, 1);
        end
        applyStimulus(0, 0, 1, 20'h00404, 1, 0, 0, 0, 0);
        sampleWindow();
        checkOutput("full_mem_addr_vld", memAddrVld, 0);
        applyStimulus(0, 0, 1, 20'h00404, 1, 1, 16'hBEEF, 0, 1);
        sampleWindow();
        checkOutput("full_pop_mem_dat_gnt", memDatGnt, 1);
        checkOutput("full_pop_no_bypass", memAddrVld, 0);
        applyStimulus(0, 0, 1, 20'h00404, 1, 0, 0, 0, 0);
        sampleWindow();
        checkOutput("after_pop_cpu_gnt", cpuAddrGnt, 1);

        $display("[TB] screen data back-pressure");
        doReset();
        applyStimulus(1, 20'h00200, 0, 0, 1, 0, 0, 0, 0);
        sampleWindow();
        checkOutput("bp_scr_gnt", scrAddrGnt, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 16'hCAFE, 0, 1);
            sampleWindow();
            checkOutput("bp_hold_mem_dat_gnt", memDatGnt, 0);
            checkOutput("bp_hold_scr_vld", scrDatVld, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 16'hCAFE, 1, 1);
        sampleWindow();
        checkOutput("bp_release_mem_dat_gnt", memDatGnt, 1);

        $display("[TB] unexpected data");
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 16'h7777, 1, 1);
        sampleWindow();
        checkOutput("unexp_mem_dat_gnt", memDatGnt, 0);
        checkOutput("unexp_scr_vld", scrDatVld, 0);
        checkOutput("unexp_cpu_vld", cpuDatVld, 0);
        checkOutput("unexp_err_same_cycle", errUnexp, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            sampleWindow();
            checkOutput("unexp_err_sticky", errUnexp, 1);
        end
        doReset();
        sampleWindow();
        checkOutput("unexp_err_cleared", errUnexp, 0);

        $display("[TB] continuous contention");
        doReset();
        firstCpuGrant = -1; grantNo = 0; cpuGrants = 0; scrIdx = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1, 20'h01000 + 20'(scrIdx), 1, 20'h0F000, 1,
                          modelQ.size() > 0, DW'($urandom), 1, 1);
            sampleWindow();
            scrTaken = scrAddrGnt;
            if (scrAddrGnt || cpuAddrGnt) grantNo++;
            if (cpuAddrGnt) begin
                cpuGrants++;
                if (firstCpuGrant < 0) firstCpuGrant = grantNo;
            end
            if (scrTaken) scrIdx++;
        end
`ifdef SCREEN_MEMARB_STARVE_GUARD_EN
        checkOutput("starve_first_cpu_grant", firstCpuGrant, 9);
`else
        checkOutput("strict_cpu_grants", cpuGrants, 0);
        checkOutput("strict_scr_grants", scrIdx, 12);
`endif

        $display("[TB] randomized traffic");
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                doReset();
            end else begin
                @(posedge clk); #1;
                if (!(scrAddrVld && !lastScrHs)) begin
                    scrAddrVld = ($urandom_range(0, 3) != 0);
                    scrAddr    = AW'($urandom);
                end
                if (!(cpuAddrVld && !lastCpuHs)) begin
                    cpuAddrVld = ($urandom_range(0, 1) != 0);
                    cpuAddr    = AW'($urandom);
                end
                if (!(memDatVld && !lastMemDatHs)) begin
                    memDatVld = (modelQ.size() > 0) && ($urandom_range(0, 2) != 0);
                    memDat    = DW'($urandom);
                end
                memAddrGnt = ($urandom_range(0, 2) != 0);
                scrDatGnt  = ($urandom_range(0, 3) != 0);
                cpuDatGnt  = ($urandom_range(0, 1) != 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleWindow();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
